// File: rtl/fb_sdram_arbiter.sv
// Frame-buffer SDRAM arbiter.
// Pixel writes are range-checked and converted to word addresses, then queued.
// Display reads are held as a single pending request. One bridge transfer runs
// at a time. Reads have priority, but a full write queue gets the next grant
// after a read. A stalled transfer is abandoned after TIMEOUT cycles, and ERR
// is set and held.
module fb_sdram_arbiter #(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int WFIFO_DEPTH = 8,
   parameter int TIMEOUT     = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   // pixel write side
   input  logic        WR_VALID,
   output logic        WR_READY,
   input  logic [9:0]  WR_X,
   input  logic [9:0]  WR_Y,
   input  logic [7:0]  WR_I,
   // display read side
   input  logic        RD_REQ,
   output logic        RD_READY,
   input  logic [18:0] RD_ADDR,
   output logic        RD_VALID,
   output logic [31:0] RD_DATA,
   // SDRAM bridge master side
   output logic [18:0] BR_ADDR,
   output logic [3:0]  BR_BYTE_EN,
   output logic        BR_READ,
   output logic        BR_WRITE,
   output logic [31:0] BR_WRITE_DATA,
   input  logic        BR_ACK,
   input  logic [31:0] BR_READ_DATA,
   // status
   output logic [3:0]  FIFO_LEVEL,
   output logic [15:0] DROP_CNT,
   output logic        ERR
);

   localparam int PTR_W = $clog2(WFIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [9:0]       X_LIM     = 10'(H_RES);
   localparam logic [9:0]       Y_LIM     = 10'(V_RES);
   localparam logic [18:0]      LINE_W    = 19'(H_RES);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(WFIFO_DEPTH);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_BUS  = 2'd1,
      WR_BUS  = 2'd2,
      RD_DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   // write queue storage and control
   logic [18:0]      fifo_addr [WFIFO_DEPTH];
   logic [7:0]       fifo_data [WFIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LVL_W-1:0] level;
   logic             fifo_full, fifo_empty;

   // request / arbitration state
   logic             rd_pending;
   logic [18:0]      rd_addr_q;
   logic             last_rd;
   logic [CNT_W-1:0] wait_cnt;

   // per-cycle events
   logic [18:0] pix_addr;
   logic        in_range, wr_fire, push, drop, pop, rd_tmo, wr_tmo;

   assign fifo_full  = (level == LVL_FULL);
   assign fifo_empty = (level == '0);
   assign WR_READY   = !fifo_full;
   assign RD_READY   = !rd_pending;
   assign FIFO_LEVEL = 4'(level);

   assign pix_addr = 19'(WR_Y) * LINE_W + 19'(WR_X);
   assign in_range = (WR_X < X_LIM) && (WR_Y < Y_LIM);
   assign wr_fire  = WR_VALID && WR_READY;
   assign push     = wr_fire && in_range;
   assign drop     = wr_fire && !in_range;

   // Next-state selection and transfer-completion events.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      rd_tmo    = 1'b0;
      wr_tmo    = 1'b0;
      case (state)
         IDLE: begin
            // A full queue blocks a read only when the previous grant went to a read.
            if (rd_pending && !(fifo_full && last_rd))
               state_nxt = RD_BUS;
            else if (!fifo_empty)
               state_nxt = WR_BUS;
         end
         RD_BUS: begin
            if (BR_ACK) begin
               state_nxt = RD_DONE;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt = IDLE;
               rd_tmo    = 1'b1;
            end
         end
         WR_BUS: begin
            if (BR_ACK) begin
               state_nxt = IDLE;
               pop       = 1'b1;
            end else if (wait_cnt == WAIT_LAST) begin
               // A stalled write is discarded so the queue cannot lock up.
               state_nxt = IDLE;
               pop       = 1'b1;
               wr_tmo    = 1'b1;
            end
         end
         RD_DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state, pending read, last-grant memory, wait counter and sticky error.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         rd_pending <= 1'b0;
         last_rd    <= 1'b0;
         wait_cnt   <= '0;
         ERR        <= 1'b0;
      end else begin
         state <= state_nxt;
         if (RD_REQ && !rd_pending)
            rd_pending <= 1'b1;
         else if (state == RD_BUS && (BR_ACK || rd_tmo))
            rd_pending <= 1'b0;
         if (state == IDLE && state_nxt == RD_BUS)
            last_rd <= 1'b1;
         else if (state == IDLE && state_nxt == WR_BUS)
            last_rd <= 1'b0;
         if ((state == RD_BUS || state == WR_BUS) && state_nxt == state)
            wait_cnt <= wait_cnt + CNT_W'(1);
         else
            wait_cnt <= '0;
         if (rd_tmo || wr_tmo)
            ERR <= 1'b1;
      end
   end

   // Latch the read address when the request is accepted.
   always_ff @(posedge CLK) begin
      if (RD_REQ && !rd_pending)
         rd_addr_q <= RD_ADDR;
   end

   // Queue pointers, occupancy and saturating drop counter.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         DROP_CNT <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         if (drop && DROP_CNT != 16'hFFFF)
            DROP_CNT <= DROP_CNT + 16'd1;
      end
   end

   // Queue storage; contents are meaningless until written, so no reset.
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_addr[wr_ptr] <= pix_addr;
         fifo_data[wr_ptr] <= WR_I;
      end
   end

   // Registered bridge command, driven from the state being entered.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         BR_READ       <= 1'b0;
         BR_WRITE      <= 1'b0;
         BR_ADDR       <= '0;
         BR_BYTE_EN    <= '0;
         BR_WRITE_DATA <= '0;
      end else begin
         BR_READ  <= (state_nxt == RD_BUS);
         BR_WRITE <= (state_nxt == WR_BUS);
         case (state_nxt)
            RD_BUS: begin
               BR_ADDR       <= rd_addr_q;
               BR_BYTE_EN    <= 4'b1111;
               BR_WRITE_DATA <= '0;
            end
            WR_BUS: begin
               BR_ADDR       <= fifo_addr[rd_ptr];
               BR_BYTE_EN    <= 4'b0001;
               BR_WRITE_DATA <= {24'b0, fifo_data[rd_ptr]};
            end
            default: begin
               BR_ADDR       <= '0;
               BR_BYTE_EN    <= '0;
               BR_WRITE_DATA <= '0;
            end
         endcase
      end
   end

   // Read return: one-cycle strobe with captured data, or zero on timeout.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         RD_VALID <= 1'b0;
         RD_DATA  <= '0;
      end else begin
         RD_VALID <= (state_nxt == RD_DONE) || rd_tmo;
         if (state == RD_BUS && BR_ACK)
            RD_DATA <= BR_READ_DATA;
         else if (rd_tmo)
            RD_DATA <= '0;
      end
   end

endmodule

// File: tb/tb_fb_sdram_arbiter.sv
// Directed testbench for fb_sdram_arbiter.
module tb_fb_sdram_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        WR_VALID, WR_READY;
   logic [9:0]  WR_X, WR_Y;
   logic [7:0]  WR_I;
   logic        RD_REQ, RD_READY;
   logic [18:0] RD_ADDR;
   logic        RD_VALID;
   logic [31:0] RD_DATA;
   logic [18:0] BR_ADDR;
   logic [3:0]  BR_BYTE_EN;
   logic        BR_READ, BR_WRITE;
   logic [31:0] BR_WRITE_DATA;
   logic        BR_ACK;
   logic [31:0] BR_READ_DATA;
   logic [3:0]  FIFO_LEVEL;
   logic [15:0] DROP_CNT;
   logic        ERR;

   int checks = 0;
   int errors = 0;

   fb_sdram_arbiter dut (
      .CLK(CLK), .RESET(RESET),
      .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_X(WR_X), .WR_Y(WR_Y), .WR_I(WR_I),
      .RD_REQ(RD_REQ), .RD_READY(RD_READY), .RD_ADDR(RD_ADDR), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
      .BR_ADDR(BR_ADDR), .BR_BYTE_EN(BR_BYTE_EN), .BR_READ(BR_READ), .BR_WRITE(BR_WRITE),
      .BR_WRITE_DATA(BR_WRITE_DATA), .BR_ACK(BR_ACK), .BR_READ_DATA(BR_READ_DATA),
      .FIFO_LEVEL(FIFO_LEVEL), .DROP_CNT(DROP_CNT), .ERR(ERR)
   );

   // 50 MHz clock
   always #10 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      tick; tick;
      checks++; if (BR_READ !== 1'b0) begin errors++; $display("FAIL rst_br_read got %0h want 0", BR_READ); end
      checks++; if (BR_WRITE !== 1'b0) begin errors++; $display("FAIL rst_br_write got %0h want 0", BR_WRITE); end
      checks++; if (BR_ADDR !== 19'd0) begin errors++; $display("FAIL rst_br_addr got %0h want 0", BR_ADDR); end
      checks++; if (BR_BYTE_EN !== 4'd0) begin errors++; $display("FAIL rst_br_be got %0h want 0", BR_BYTE_EN); end
      checks++; if (BR_WRITE_DATA !== 32'd0) begin errors++; $display("FAIL rst_br_wdata got %0h want 0", BR_WRITE_DATA); end
      checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %0h want 0", RD_VALID); end
      checks++; if (RD_DATA !== 32'd0) begin errors++; $display("FAIL rst_rd_data got %0h want 0", RD_DATA); end
      checks++; if (WR_READY !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %0h want 1", WR_READY); end
      checks++; if (RD_READY !== 1'b1) begin errors++; $display("FAIL rst_rd_ready got %0h want 1", RD_READY); end
      checks++; if (FIFO_LEVEL !== 4'd0) begin errors++; $display("FAIL rst_level got %0d want 0", FIFO_LEVEL); end
      checks++; if (DROP_CNT !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d want 0", DROP_CNT); end
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rst_err got %0h want 0", ERR); end
      RESET = 1'b0;
      tick;
   endtask

   task automatic test_write;
      WR_X = 10'd5; WR_Y = 10'd2; WR_I = 8'h3C; WR_VALID = 1'b1;
      checks++; if (WR_READY !== 1'b1) begin errors++; $display("FAIL wr_ready got %0h want 1", WR_READY); end
      tick;
      WR_VALID = 1'b0;
      checks++; if (FIFO_LEVEL !== 4'd1) begin errors++; $display("FAIL wr_level1 got %0d want 1", FIFO_LEVEL); end
      checks++; if (BR_WRITE !== 1'b0) begin errors++; $display("FAIL wr_early got %0h want 0", BR_WRITE); end
      tick;
      checks++; if (BR_WRITE !== 1'b1) begin errors++; $display("FAIL wr_cmd got %0h want 1", BR_WRITE); end
      checks++; if (BR_READ !== 1'b0) begin errors++; $display("FAIL wr_no_read got %0h want 0", BR_READ); end
      checks++; if (BR_ADDR !== 19'd1285) begin errors++; $display("FAIL wr_addr got %0d want 1285", BR_ADDR); end
      checks++; if (BR_WRITE_DATA !== 32'h3C) begin errors++; $display("FAIL wr_data got %0h want 3c", BR_WRITE_DATA); end
      checks++; if (BR_BYTE_EN !== 4'b0001) begin errors++; $display("FAIL wr_be got %0h want 1", BR_BYTE_EN); end
      tick; tick;
      checks++; if (BR_WRITE !== 1'b1 || BR_ADDR !== 19'd1285) begin errors++; $display("FAIL wr_hold got %0h/%0d want 1/1285", BR_WRITE, BR_ADDR); end
      BR_ACK = 1'b1;
      tick;
      BR_ACK = 1'b0;
      checks++; if (BR_WRITE !== 1'b0) begin errors++; $display("FAIL wr_release got %0h want 0", BR_WRITE); end
      checks++; if (FIFO_LEVEL !== 4'd0) begin errors++; $display("FAIL wr_level0 got %0d want 0", FIFO_LEVEL); end
      tick;
      checks++; if (BR_WRITE !== 1'b0) begin errors++; $display("FAIL wr_reissue got %0h want 0", BR_WRITE); end
   endtask

   task automatic test_read;
      RD_ADDR = 19'h100; RD_REQ = 1'b1;
      checks++; if (RD_READY !== 1'b1) begin errors++; $display("FAIL rd_ready got %0h want 1", RD_READY); end
      tick;  // cycle 1
      RD_REQ = 1'b0;
      checks++; if (RD_READY !== 1'b0) begin errors++; $display("FAIL rd_pending got %0h want 0", RD_READY); end
      checks++; if (BR_READ !== 1'b0) begin errors++; $display("FAIL rd_c1 got %0h want 0", BR_READ); end
      tick;  // cycle 2
      checks++; if (BR_READ !== 1'b1) begin errors++; $display("FAIL rd_c2 got %0h want 1", BR_READ); end
      checks++; if (BR_ADDR !== 19'h100) begin errors++; $display("FAIL rd_addr got %0h want 100", BR_ADDR); end
      checks++; if (BR_BYTE_EN !== 4'hF) begin errors++; $display("FAIL rd_be got %0h want f", BR_BYTE_EN); end
      checks++; if (BR_WRITE !== 1'b0) begin errors++; $display("FAIL rd_no_write got %0h want 0", BR_WRITE); end
      tick;  // cycle 3
      checks++; if (BR_READ !== 1'b1) begin errors++; $display("FAIL rd_c3 got %0h want 1", BR_READ); end
      tick;  // cycle 4
      checks++; if (BR_READ !== 1'b1 || RD_VALID !== 1'b0) begin errors++; $display("FAIL rd_c4 got %0h/%0h want 1/0", BR_READ, RD_VALID); end
      BR_ACK = 1'b1; BR_READ_DATA = 32'hDEADBEEF;
      tick;  // cycle 5
      BR_ACK = 1'b0;
      checks++; if (RD_VALID !== 1'b1) begin errors++; $display("FAIL rd_valid got %0h want 1", RD_VALID); end
      checks++; if (RD_DATA !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %0h want deadbeef", RD_DATA); end
      checks++; if (BR_READ !== 1'b0) begin errors++; $display("FAIL rd_c5 got %0h want 0", BR_READ); end
      tick;  // cycle 6
      checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL rd_valid_once got %0h want 0", RD_VALID); end
   endtask

   task automatic test_drop;
      int saw_write;
      WR_VALID = 1'b1; WR_X = 10'd640; WR_Y = 10'd0; WR_I = 8'h01;
      tick;
      WR_X = 10'd0; WR_Y = 10'd480;
      tick;
      WR_VALID = 1'b0;
      checks++; if (DROP_CNT !== 16'd2) begin errors++; $display("FAIL drop_cnt got %0d want 2", DROP_CNT); end
      checks++; if (FIFO_LEVEL !== 4'd0) begin errors++; $display("FAIL drop_level got %0d want 0", FIFO_LEVEL); end
      saw_write = 0;
      for (int c = 0; c < 4; c++) begin
         if (BR_WRITE) saw_write++;
         tick;
      end
      checks++; if (saw_write != 0) begin errors++; $display("FAIL drop_no_write got %0d want 0", saw_write); end
      // last valid pixel of the frame
      WR_VALID = 1'b1; WR_X = 10'd639; WR_Y = 10'd479; WR_I = 8'hFF;
      tick;
      WR_VALID = 1'b0;
      checks++; if (FIFO_LEVEL !== 4'd1) begin errors++; $display("FAIL edge_level got %0d want 1", FIFO_LEVEL); end
      tick;
      checks++; if (BR_WRITE !== 1'b1 || BR_ADDR !== 19'd307199) begin errors++; $display("FAIL edge_addr got %0h/%0d want 1/307199", BR_WRITE, BR_ADDR); end
      checks++; if (BR_WRITE_DATA !== 32'hFF) begin errors++; $display("FAIL edge_data got %0h want ff", BR_WRITE_DATA); end
      BR_ACK = 1'b1;
      tick;
      BR_ACK = 1'b0;
      checks++; if (FIFO_LEVEL !== 4'd0 || DROP_CNT !== 16'd2) begin errors++; $display("FAIL edge_after got %0d/%0d want 0/2", FIFO_LEVEL, DROP_CNT); end
   endtask

   task automatic test_arbitration;
      logic got [6];
      int   n, overlap, ready_bad;
      logic prev_rd, prev_wr;
      RD_ADDR = 19'h55; RD_REQ = 1'b1;
      WR_X = 10'd1; WR_Y = 10'd0; WR_I = 8'h11; WR_VALID = 1'b1;
      BR_READ_DATA = 32'h12345678;
      for (int c = 0; c < 10; c++) tick;
      checks++; if (FIFO_LEVEL !== 4'd8) begin errors++; $display("FAIL arb_full got %0d want 8", FIFO_LEVEL); end
      checks++; if (WR_READY !== 1'b0) begin errors++; $display("FAIL arb_wr_ready got %0h want 0", WR_READY); end
      checks++; if (BR_READ !== 1'b1) begin errors++; $display("FAIL arb_read_held got %0h want 1", BR_READ); end
      n = 0; overlap = 0; ready_bad = 0;
      prev_rd = BR_READ; prev_wr = BR_WRITE;
      for (int c = 0; c < 80 && n < 6; c++) begin
         BR_ACK = BR_READ | BR_WRITE;
         if (BR_READ && BR_WRITE) overlap++;
         if (WR_READY !== (FIFO_LEVEL != 4'd8)) ready_bad++;
         tick;
         if (BR_WRITE && !prev_wr) begin got[n] = 1'b1; n++; end
         else if (BR_READ && !prev_rd) begin got[n] = 1'b0; n++; end
         prev_rd = BR_READ; prev_wr = BR_WRITE;
      end
      checks++; if (n != 6) begin errors++; $display("FAIL arb_grants got %0d want 6", n); end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got[i] !== ((i % 2) == 0)) begin errors++; $display("FAIL arb_order grant %0d got wr=%0d want wr=%0d", i, got[i], (i % 2) == 0); end
      end
      checks++; if (overlap != 0) begin errors++; $display("FAIL arb_overlap got %0d want 0", overlap); end
      checks++; if (ready_bad != 0) begin errors++; $display("FAIL arb_ready_track got %0d want 0", ready_bad); end
      RD_REQ = 1'b0; WR_VALID = 1'b0;
      for (int c = 0; c < 60; c++) begin
         BR_ACK = BR_READ | BR_WRITE;
         tick;
      end
      BR_ACK = 1'b0;
      checks++; if (FIFO_LEVEL !== 4'd0 || RD_READY !== 1'b1) begin errors++; $display("FAIL arb_drain got %0d/%0h want 0/1", FIFO_LEVEL, RD_READY); end
      checks++; if (BR_READ !== 1'b0 || BR_WRITE !== 1'b0) begin errors++; $display("FAIL arb_quiet got %0h/%0h want 0/0", BR_READ, BR_WRITE); end
   endtask

   task automatic test_timeout;
      int cnt;
      BR_READ_DATA = 32'hA5A5A5A5;
      RD_ADDR = 19'h77; RD_REQ = 1'b1;
      tick;
      RD_REQ = 1'b0;
      tick;
      checks++; if (BR_READ !== 1'b1) begin errors++; $display("FAIL tmo_start got %0h want 1", BR_READ); end
      cnt = 0;
      for (int c = 0; c < 400 && BR_READ === 1'b1; c++) begin
         cnt++;
         tick;
      end
      checks++; if (cnt != 255) begin errors++; $display("FAIL tmo_cycles got %0d want 255", cnt); end
      checks++; if (BR_READ !== 1'b0) begin errors++; $display("FAIL tmo_drop got %0h want 0", BR_READ); end
      checks++; if (RD_VALID !== 1'b1 || RD_DATA !== 32'd0) begin errors++; $display("FAIL tmo_rdval got %0h/%0h want 1/0", RD_VALID, RD_DATA); end
      checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL tmo_err got %0h want 1", ERR); end
      tick;
      checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL tmo_rdval_once got %0h want 0", RD_VALID); end
      WR_X = 10'd3; WR_Y = 10'd1; WR_I = 8'h42; WR_VALID = 1'b1;
      tick;
      WR_VALID = 1'b0;
      tick;
      checks++; if (BR_WRITE !== 1'b1 || BR_ADDR !== 19'd643) begin errors++; $display("FAIL tmo_wr got %0h/%0d want 1/643", BR_WRITE, BR_ADDR); end
      checks++; if (BR_WRITE_DATA !== 32'h42) begin errors++; $display("FAIL tmo_wr_data got %0h want 42", BR_WRITE_DATA); end
      BR_ACK = 1'b1;
      tick;
      BR_ACK = 1'b0;
      checks++; if (FIFO_LEVEL !== 4'd0 || ERR !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %0d/%0h want 0/1", FIFO_LEVEL, ERR); end
   endtask

   task automatic test_reset_mid;
      int saw_write;
      WR_VALID = 1'b1; WR_Y = 10'd7; WR_I = 8'h99;
      for (int k = 0; k < 3; k++) begin
         WR_X = 10'(20 + k);
         tick;
      end
      WR_VALID = 1'b0;
      tick;
      checks++; if (BR_WRITE !== 1'b1 || FIFO_LEVEL !== 4'd3) begin errors++; $display("FAIL mid_setup got %0h/%0d want 1/3", BR_WRITE, FIFO_LEVEL); end
      RESET = 1'b1;
      tick;
      RESET = 1'b0;
      checks++; if (BR_WRITE !== 1'b0) begin errors++; $display("FAIL mid_br_write got %0h want 0", BR_WRITE); end
      checks++; if (FIFO_LEVEL !== 4'd0) begin errors++; $display("FAIL mid_level got %0d want 0", FIFO_LEVEL); end
      checks++; if (WR_READY !== 1'b1) begin errors++; $display("FAIL mid_wr_ready got %0h want 1", WR_READY); end
      checks++; if (ERR !== 1'b0 || BR_ADDR !== 19'd0) begin errors++; $display("FAIL mid_err_addr got %0h/%0d want 0/0", ERR, BR_ADDR); end
      saw_write = 0;
      for (int c = 0; c < 12; c++) begin
         BR_ACK = BR_READ | BR_WRITE;
         if (BR_WRITE) saw_write++;
         tick;
      end
      BR_ACK = 1'b0;
      checks++; if (saw_write != 0) begin errors++; $display("FAIL mid_stale_write got %0d want 0", saw_write); end
   endtask

   initial begin
      RESET = 1'b1; WR_VALID = 1'b0; WR_X = '0; WR_Y = '0; WR_I = '0;
      RD_REQ = 1'b0; RD_ADDR = '0; BR_ACK = 1'b0; BR_READ_DATA = '0;
      test_reset;
      test_write;
      test_read;
      test_drop;
      test_arbitration;
      test_timeout;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
